// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher with multi-outstanding AXI-lite reads feeding an output FIFO.
// Redirects flush the FIFO and count off stale responses still owed by the interconnect.
module ifu_prefetch #(
    parameter int                   CPU_WIDTH       = 32,
    parameter int                   INS_WIDTH       = 32,
    parameter int                   FIFO_DEPTH      = 4,
    parameter int                   MAX_OUTSTANDING = 2,
    parameter logic [CPU_WIDTH-1:0] RESET_PC        = 'h8000_0000,
    parameter int                   PC_STEP         = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_post_valid,
    input  logic                 i_post_ready,
    output logic [INS_WIDTH-1:0] o_instr,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic                 o_err,
    output logic [CPU_WIDTH-1:0] araddr,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [CPU_WIDTH-1:0] rdata,
    input  logic [1:0]           rresp,
    input  logic                 rvalid,
    output logic                 rready
);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int EW = CPU_WIDTH + INS_WIDTH + 1;

    logic [CPU_WIDTH-1:0] fetch_pc_q, fetch_pc_d, araddr_q, araddr_d, base_pc;
    logic                 arvalid_q, arvalid_d, halted_q, halted_d;
    logic [IW-1:0]        inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
    logic [CPU_WIDTH-1:0] pcq_q [MAX_OUTSTANDING];
    logic [CPU_WIDTH-1:0] pcq_d [MAX_OUTSTANDING];
    logic [QW-1:0]        pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic [EW-1:0]        fifo_q [FIFO_DEPTH];
    logic [EW-1:0]        fifo_d [FIFO_DEPTH];
    logic [FW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic                 ar_fire, r_fire, push, pop, hold, issue;

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    assign araddr       = araddr_q;
    assign arvalid      = arvalid_q;
    assign rready       = inflight_q != '0;
    assign o_post_valid = fifo_cnt_q != '0;
    assign {o_pc, o_instr, o_err} = fifo_q[rd_ptr_q];

    always_comb begin
        ar_fire    = arvalid_q && arready;
        r_fire     = rvalid && rready;
        push       = r_fire && drop_cnt_q == '0 && !i_redirect;
        pop        = o_post_valid && i_post_ready && !i_redirect;
        hold       = arvalid_q && !arready;
        pcq_d      = pcq_q;
        if (ar_fire) pcq_d[pcq_wr_q] = araddr_q;
        pcq_wr_d   = ar_fire ? qinc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d   = r_fire ? qinc(pcq_rd_q) : pcq_rd_q;
        inflight_d = inflight_q + IW'(ar_fire) - IW'(r_fire);
        // A held AR cannot be withdrawn, so its response is owed a drop as well.
        drop_cnt_d = i_redirect ? inflight_d + IW'(hold)
                                : drop_cnt_q - IW'(r_fire && drop_cnt_q != '0);
        fifo_d     = fifo_q;
        if (push) fifo_d[wr_ptr_q] = {pcq_q[pcq_rd_q], rdata[INS_WIDTH-1:0], rresp != 2'b00};
        wr_ptr_d   = i_redirect ? '0 : wr_ptr_q + FW'(push);
        rd_ptr_d   = i_redirect ? '0 : rd_ptr_q + FW'(pop);
        fifo_cnt_d = i_redirect ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
        halted_d   = !i_redirect && (halted_q || (push && rresp != 2'b00));
        // FIFO space for every read is reserved at issue, so R never needs backpressure.
        base_pc    = i_redirect ? i_redirect_pc : fetch_pc_q;
        issue      = !hold && !halted_d && int'(inflight_d) < MAX_OUTSTANDING
                     && int'(inflight_d) + int'(fifo_cnt_d) < FIFO_DEPTH;
        arvalid_d  = hold || issue;
        araddr_d   = issue ? base_pc : araddr_q;
        fetch_pc_d = issue ? base_pc + CPU_WIDTH'(PC_STEP) : base_pc;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            halted_q   <= 1'b0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) pcq_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            halted_q   <= halted_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            pcq_q      <= pcq_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench with an in-order AXI-lite read slave model and an expected-pc scoreboard.
module tb_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        post_ready = 1'b0;
    logic        post_valid, err, arvalid, rready;
    logic [31:0] instr, pc, araddr;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    ifu_prefetch dut (
        .i_clk(clk), .i_rst(rst), .i_redirect(redir), .i_redirect_pc(redir_pc),
        .o_post_valid(post_valid), .i_post_ready(post_ready), .o_instr(instr), .o_pc(pc),
        .o_err(err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int lat = 1;
    int ar_mode = 0;
    int ar_cnt = 0;
    int r_cnt = 0;
    int pops = 0;
    int max_seen = 0;
    int p0;
    logic [31:0] q_addr[$];
    int          q_t[$];
    logic [31:0] err_addr = 32'h1;
    logic [31:0] exp_pc = 32'h8000_0000;
    logic [31:0] last_ar = '0;
    logic [31:0] held_addr = '0;
    logic [31:0] old_addr;
    logic        held = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic cyc();
        logic fire_ar;
        if (rst) begin
            q_addr.delete();
            q_t.delete();
            arready = 1'b0;
            rvalid = 1'b0;
            rdata = '0;
            rresp = '0;
            held = 1'b0;
            exp_pc = 32'h8000_0000;
        end else begin
            arready = (ar_mode == 0) || (ar_mode > 0 && cyc_n % ar_mode == 0);
            rvalid = q_addr.size() > 0 && q_t[0] <= cyc_n;
            rdata = rvalid ? mem(q_addr[0]) : '0;
            rresp = (rvalid && q_addr[0] == err_addr) ? 2'b10 : 2'b00;
            if (held) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, held_addr);
            end
            held = arvalid && !arready;
            held_addr = araddr;
            fire_ar = arvalid && arready;
            if (fire_ar) begin
                q_addr.push_back(araddr);
                q_t.push_back(cyc_n + lat);
                last_ar = araddr;
                ar_cnt++;
            end
            if (rvalid && rready) begin
                void'(q_addr.pop_front());
                void'(q_t.pop_front());
                r_cnt++;
            end
            if (fire_ar) check("max_outstanding", q_addr.size() <= 2, 1);
            if (q_addr.size() > max_seen) max_seen = q_addr.size();
            if (redir) exp_pc = redir_pc;
            else if (post_valid && post_ready) begin
                check("o_pc", pc, exp_pc);
                check("o_instr", instr, mem(exp_pc));
                check("o_err", err, exp_pc == err_addr);
                exp_pc += 32'd4;
                pops++;
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) cyc();
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_post_valid", post_valid, 0);
        check("rst_err", err, 0);

        // zero-latency slave, IDU always ready
        rst = 1'b0;
        post_ready = 1'b1;
        cyc();
        check("first_arvalid", arvalid, 1);
        check("first_araddr", araddr, 32'h8000_0000);
        p0 = pops;
        repeat (20) cyc();
        check("stream_pops", pops - p0, 18);

        // IDU stalls: exactly FIFO_DEPTH reads then AR stops
        post_ready = 1'b0;
        repeat (12) cyc();
        check("stall_arvalid", arvalid, 0);
        check("stall_post_valid", post_valid, 1);
        check("stall_fetched", ar_cnt - pops, 4);
        check("stall_returned", r_cnt - pops, 4);
        post_ready = 1'b1;
        p0 = pops;
        repeat (20) cyc();
        check("release_pops", pops - p0, 20);

        // slow slave with stalled arready
        lat = 5;
        ar_mode = 3;
        max_seen = 0;
        p0 = pops;
        repeat (60) cyc();
        check("slow_max_seen", max_seen, 2);
        check("slow_progress", pops > p0, 1);

        // redirect with one read in flight and one AR held
        ar_mode = -1;
        lat = 1;
        repeat (15) cyc();
        check("drain_arvalid", arvalid, 1);
        check("drain_rready", rready, 0);
        lat = 6;
        ar_mode = 0;
        cyc();
        ar_mode = -1;
        cyc();
        old_addr = araddr;
        check("pre_redir_arvalid", arvalid, 1);
        check("pre_redir_rready", rready, 1);
        redir = 1'b1;
        redir_pc = 32'h8000_1000;
        cyc();
        redir = 1'b0;
        check("redir_hold_addr", araddr, old_addr);
        check("redir_post_valid", post_valid, 0);
        ar_mode = 0;
        lat = 2;
        p0 = pops;
        repeat (30) cyc();
        check("redir_progress", pops > p0, 1);

        // error response halts fetching
        lat = 1;
        repeat (10) cyc();
        err_addr = 32'h8000_0008;
        redir = 1'b1;
        redir_pc = 32'h8000_0000;
        cyc();
        redir = 1'b0;
        repeat (20) cyc();
        check("halt_arvalid", arvalid, 0);
        check("halt_last_ar", last_ar, 32'h8000_000C);
        check("halt_exp_pc", exp_pc, 32'h8000_0010);
        check("halt_post_valid", post_valid, 0);

        // redirect restarts fetching and the address wraps
        err_addr = 32'h1;
        redir = 1'b1;
        redir_pc = 32'hFFFF_FFF8;
        cyc();
        redir = 1'b0;
        check("restart_arvalid", arvalid, 1);
        check("restart_araddr", araddr, 32'hFFFF_FFF8);
        repeat (10) cyc();
        check("wrap_exp_pc", exp_pc, 32'h0000_0018);

        // reset mid-burst
        check("pre_rst_busy", arvalid | rready | post_valid, 1);
        rst = 1'b1;
        cyc();
        check("mid_rst_arvalid", arvalid, 0);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_post_valid", post_valid, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        cyc();
        check("after_rst_arvalid", arvalid, 1);
        check("after_rst_araddr", araddr, 32'h8000_0000);
        repeat (10) cyc();
        check("after_rst_exp_pc", exp_pc, 32'h8000_0020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
